// File: rtl/bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg: shared definitions for the branch prediction unit.
//   - 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   - counter value loaded at reset
//   - default BTB depth
// -----------------------------------------------------------------------------
package bpu_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  localparam logic [1:0] CTR_RST       = CTR_WNT;
  localparam int         BTB_DEPTH_DEF = 16;

endpackage

// File: rtl/bpu_ctr.sv
// -----------------------------------------------------------------------------
// bpu_ctr: combinational next-state of a 2-bit saturating direction counter.
// Ports:
//   i_ctr          in  2  current counter value
//   i_taken        in  1  resolved direction (count up when set)
//   i_force_strong in  1  load strongly-taken regardless of direction (jumps)
//   o_ctr          out 2  next counter value
// -----------------------------------------------------------------------------
module bpu_ctr
  import bpu_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_force_strong,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_force_strong) begin
      o_ctr = CTR_ST;
    end else if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/bpu.sv
// -----------------------------------------------------------------------------
// bpu: direct-mapped BTB with 2-bit direction counters.
//   Lookup is combinational on if_pc_i; EX trains the table with the resolved
//   outcome; a mispredict produces a registered one-cycle redirect pulse.
// Parameters: PC_W (PC width), ENTRIES (BTB depth, power of two, >= 2).
// Ports:
//   clock, reset_n                       clock / async active-low reset
//   if_pc_i -> pred_taken_o, pred_pc_o   fetch-side prediction
//   ex_valid_i, ex_pc_i, ex_pred_pc_i,
//   ex_is_branch_i/jal_i/jalr_i,
//   ex_taken_i, ex_npc_i                 resolved control transfer from EX
//   redirect_valid_o, redirect_pc_o      mispredict flush request
//   perf_branch_cnt_o, perf_miss_cnt_o   performance counters
// Build option: YSYX_23060251_BPU_PERF_EN enables the performance counters;
//   when undefined both counter ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module bpu
  import bpu_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = BTB_DEPTH_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [PC_W-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_pc_o,
  input  logic            ex_valid_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [PC_W-1:0] ex_pred_pc_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic            ex_taken_i,
  input  logic [PC_W-1:0] ex_npc_i,
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     perf_branch_cnt_o,
  output logic [31:0]     perf_miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Control state (reset) and entry payload (not reset; qualified by valid).
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic               r_jump   [ENTRIES];

  logic               r_redir_vld_p1;
  logic [PC_W-1:0]    r_redir_pc_p1;

  // PCs are word aligned; the low two bits never index or tag.
  logic w_unused_lsb;
  assign w_unused_lsb = ^{if_pc_i[1:0], ex_pc_i[1:0]};

  // ---- stage p0: combinational lookup for fetch ----
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;

  assign w_if_idx     = if_pc_i[IDX_W+1:2];
  assign w_if_tag     = if_pc_i[PC_W-1:IDX_W+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken_o = w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1]);
  assign pred_pc_o    = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + PC_W'(4));

  // ---- stage p0: EX-side training decisions ----
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_ex_jump;
  logic             w_ex_taken;
  logic             w_upd_hit;
  logic             w_upd_alloc;
  logic             w_wr_target;
  logic [1:0]       w_ctr_nxt;
  logic             w_mispred;

  assign w_ex_idx    = ex_pc_i[IDX_W+1:2];
  assign w_ex_tag    = ex_pc_i[PC_W-1:IDX_W+2];
  assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_jump   = ex_is_jal_i || ex_is_jalr_i;
  assign w_ex_taken  = w_ex_jump || (ex_is_branch_i && ex_taken_i);
  assign w_upd_hit   = ex_valid_i && w_ex_hit && (ex_is_branch_i || w_ex_jump);
  // A not-taken branch that misses leaves the table alone.
  assign w_upd_alloc = ex_valid_i && !w_ex_hit && w_ex_taken;
  assign w_wr_target = w_upd_alloc || (w_upd_hit && w_ex_taken);
  assign w_mispred   = ex_valid_i && (ex_npc_i != ex_pred_pc_i);

  bpu_ctr u_ctr (
    .i_ctr          (r_ctr[w_ex_idx]),
    .i_taken        (ex_taken_i),
    .i_force_strong (w_ex_jump),
    .o_ctr          (w_ctr_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RST;
    end else if (w_upd_alloc) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_ctr[w_ex_idx]   <= w_ex_jump ? CTR_ST : CTR_WT;
    end else if (w_upd_hit) begin
      r_ctr[w_ex_idx]   <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_upd_alloc) r_tag[w_ex_idx] <= w_ex_tag;
    if (w_wr_target) r_target[w_ex_idx] <= ex_npc_i;
    if (w_upd_alloc || (w_upd_hit && w_ex_jump)) r_jump[w_ex_idx] <= w_ex_jump;
  end

  // ---- stage p1: registered redirect ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_redir_vld_p1 <= 1'b0;
      r_redir_pc_p1  <= '0;
    end else begin
      r_redir_vld_p1 <= w_mispred;
      if (w_mispred) r_redir_pc_p1 <= ex_npc_i;
    end
  end

  assign redirect_valid_o = r_redir_vld_p1;
  assign redirect_pc_o    = r_redir_pc_p1;

`ifdef YSYX_23060251_BPU_PERF_EN
  logic [31:0] r_perf_branch;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_branch <= '0;
      r_perf_miss   <= '0;
    end else begin
      if (ex_valid_i) r_perf_branch <= r_perf_branch + 32'd1;
      if (w_mispred)  r_perf_miss   <= r_perf_miss + 32'd1;
    end
  end

  assign perf_branch_cnt_o = r_perf_branch;
  assign perf_miss_cnt_o   = r_perf_miss;
`else
  assign perf_branch_cnt_o = '0;
  assign perf_miss_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_bpu.sv
// -----------------------------------------------------------------------------
// tb_bpu: directed-vector bench for bpu (default parameters, ENTRIES = 16).
// -----------------------------------------------------------------------------
module tb_bpu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_pred_pc;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_taken;
  logic [31:0] ex_npc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branch_cnt;
  logic [31:0] perf_miss_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  bpu dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .if_pc_i           (if_pc),
    .pred_taken_o      (pred_taken),
    .pred_pc_o         (pred_pc),
    .ex_valid_i        (ex_valid),
    .ex_pc_i           (ex_pc),
    .ex_pred_pc_i      (ex_pred_pc),
    .ex_is_branch_i    (ex_is_branch),
    .ex_is_jal_i       (ex_is_jal),
    .ex_is_jalr_i      (ex_is_jalr),
    .ex_taken_i        (ex_taken),
    .ex_npc_i          (ex_npc),
    .redirect_valid_o  (redirect_valid),
    .redirect_pc_o     (redirect_pc),
    .perf_branch_cnt_o (perf_branch_cnt),
    .perf_miss_cnt_o   (perf_miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ex_set(input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] npc,
                        input logic br, input logic jal, input logic jalr, input logic tk);
    ex_valid     = 1'b1;
    ex_pc        = pc;
    ex_pred_pc   = pred;
    ex_npc       = npc;
    ex_is_branch = br;
    ex_is_jal    = jal;
    ex_is_jalr   = jalr;
    ex_taken     = tk;
  endtask

  task automatic ex_clr();
    ex_valid     = 1'b0;
    ex_pc        = '0;
    ex_pred_pc   = '0;
    ex_npc       = '0;
    ex_is_branch = 1'b0;
    ex_is_jal    = 1'b0;
    ex_is_jalr   = 1'b0;
    ex_taken     = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] npc,
                         input logic br, input logic jal, input logic jalr, input logic tk);
    ex_set(pc, pred, npc, br, jal, jalr, tk);
    step();
    ex_clr();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    chk({tag, "_pc"}, pred_pc, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    if_pc   = '0;
    ex_clr();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rv",   {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc",  redirect_pc, 32'd0);
    chk("rst_pbr",  perf_branch_cnt, 32'd0);
    chk("rst_pmis", perf_miss_cnt, 32'd0);
    reset_n = 1'b1;
    step();

    look("cold", 32'h8000_0000, 1'b0, 32'h8000_0004);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // jal allocates and mispredicts
    resolve(32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jal_rv",  {31'd0, redirect_valid}, 32'd1);
    chk("jal_rpc", redirect_pc, 32'h8000_0100);
    look("jal_hit", 32'h8000_0010, 1'b1, 32'h8000_0100);
    step();
    chk("jal_pulse_end", {31'd0, redirect_valid}, 32'd0);

    // branch training at 0x8000_0020
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_alloc_rpc", redirect_pc, 32'h8000_0040);
    look("br_c2", 32'h8000_0020, 1'b1, 32'h8000_0040);
    resolve(32'h8000_0020, 32'h8000_0040, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_nt_rpc", redirect_pc, 32'h8000_0024);
    look("br_c1", 32'h8000_0020, 1'b0, 32'h8000_0024);
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_ok_rv", {31'd0, redirect_valid}, 32'd0);
    look("br_c0", 32'h8000_0020, 1'b0, 32'h8000_0024);
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    look("br_sat_lo", 32'h8000_0020, 1'b0, 32'h8000_0024);
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    look("br_up_c2", 32'h8000_0020, 1'b1, 32'h8000_0040);
    resolve(32'h8000_0020, 32'h8000_0040, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    resolve(32'h8000_0020, 32'h8000_0040, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    look("br_c3", 32'h8000_0020, 1'b1, 32'h8000_0040);
    resolve(32'h8000_0020, 32'h8000_0040, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    look("br_sat_hi", 32'h8000_0020, 1'b1, 32'h8000_0040);
    resolve(32'h8000_0020, 32'h8000_0040, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    look("br_down_c1", 32'h8000_0020, 1'b0, 32'h8000_0024);

    // aliasing: 0x8000_0050 shares index 4 with 0x8000_0010
    resolve(32'h8000_0050, 32'h8000_0054, 32'h8000_0200, 1'b0, 1'b1, 1'b0, 1'b0);
    look("alias_old", 32'h8000_0010, 1'b0, 32'h8000_0014);
    look("alias_new", 32'h8000_0050, 1'b1, 32'h8000_0200);

    // same-cycle update and lookup at one index
    if_pc = 32'h8000_0050;
    ex_set(32'h8000_0050, 32'h8000_0200, 32'h8000_0300, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("same_old_pc", pred_pc, 32'h8000_0200);
    step();
    ex_clr();
    #1;
    chk("same_new_pc", pred_pc, 32'h8000_0300);
    chk("same_rpc", redirect_pc, 32'h8000_0300);

    // back-to-back mispredicts
    ex_set(32'h8000_0060, 32'h8000_0064, 32'h8000_0400, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("b2b_rv0",  {31'd0, redirect_valid}, 32'd1);
    chk("b2b_rpc0", redirect_pc, 32'h8000_0400);
    ex_set(32'h8000_0070, 32'h8000_0074, 32'h8000_0500, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("b2b_rv1",  {31'd0, redirect_valid}, 32'd1);
    chk("b2b_rpc1", redirect_pc, 32'h8000_0500);
    ex_clr();
    step();
    chk("b2b_end", {31'd0, redirect_valid}, 32'd0);

    // reset clears the table asynchronously
    reset_n = 1'b0;
    #1;
    look("rst_clear", 32'h8000_0050, 1'b0, 32'h8000_0054);
    reset_n = 1'b1;
    step();

    // 5 resolves, 2 mispredicts
    resolve(32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    resolve(32'h8000_0010, 32'h8000_0100, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    resolve(32'h8000_0020, 32'h8000_0024, 32'h8000_0024, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h8000_0030, 32'h8000_0034, 32'h8000_0080, 1'b1, 1'b0, 1'b0, 1'b1);
    resolve(32'h8000_0010, 32'h8000_0100, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    look("nt_no_alloc", 32'h8000_0020, 1'b0, 32'h8000_0024);
`ifdef YSYX_23060251_BPU_PERF_EN
    chk("perf_branch", perf_branch_cnt, 32'd5);
    chk("perf_miss",   perf_miss_cnt,   32'd2);
`else
    chk("perf_branch", perf_branch_cnt, 32'd0);
    chk("perf_miss",   perf_miss_cnt,   32'd0);
`endif

    // reset lands between a mispredicting cycle and its edge
    ex_set(32'h8000_0040, 32'h8000_0044, 32'h8000_0900, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    step();
    chk("mid_rst_rv",   {31'd0, redirect_valid}, 32'd0);
    chk("mid_rst_rpc",  redirect_pc, 32'd0);
    chk("mid_rst_pbr",  perf_branch_cnt, 32'd0);
    chk("mid_rst_pmis", perf_miss_cnt, 32'd0);
    ex_clr();
    reset_n = 1'b1;
    step();
    chk("mid_rst_rv_after", {31'd0, redirect_valid}, 32'd0);
    look("mid_rst_noalloc", 32'h8000_0040, 1'b0, 32'h8000_0044);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
